// File: rtl/wb_pic.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pic
//  Purpose  : Wishbone IO-mapped priority interrupt controller. Latches
//             edge-triggered IRQ requests, masks them, raises intr_o toward
//             the CPU and supplies the 8-bit vector during the CPU acknowledge.
//             Fully-nested priority (bit 0 highest) with non-specific EOI.
//  Ports    : wb_clk_i / wb_rst_ni   clock, async active-low reset
//             wb_adr_i               word select (0: IRR|IMR, 1: ISR|BASE)
//             wb_dat_i / wb_dat_o    16-bit write / read data
//             wb_sel_i               byte lanes ([0] low, [1] high)
//             wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o   bus handshake
//             irq_i                  asynchronous interrupt request lines
//             intr_o / inta_i        CPU interrupt request / acknowledge
//             vec_o                  vector latched at acknowledge
//  Revision : 1.0  initial release
// ============================================================================
module wb_pic #(
  parameter int         NIRQ    = 8,
  parameter logic [7:0] VEC_RST = 8'h08
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wb_adr_i,
  input  logic [15:0]     wb_dat_i,
  output logic [15:0]     wb_dat_o,
  input  logic [1:0]      wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  input  logic [NIRQ-1:0] irq_i,
  output logic            intr_o,
  input  logic            inta_i,
  output logic [7:0]      vec_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [NIRQ-1:0] sync1, sync2, sync3;
  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] imr, irr, isr;
  logic [NIRQ-1:0] irr_nx, isr_nx;
  logic [NIRQ-1:0] pend, win_oh, isr_oh;
  logic [NIRQ-1:0] take_mask, eoi_mask;
  logic [4:0]      base;
  logic [2:0]      win_idx;
  logic            eligible;
  logic            inta_d;
  logic            acc, wr, eoi, take;
  logic [7:0]      imr8, irr8, isr8;
  logic [15:0]     rd_data;
  logic            unused;

  // Data bits that no register stores (BASE low bits, IRR/ISR lane).
  assign unused = ^{wb_dat_i[15:8], wb_dat_i[2:0]};

  // --------------------------------------------------------------------------
  // Request capture: 2-flop synchroniser plus an edge flop per line.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      inta_d <= 1'b0;
    end else begin
      sync1  <= irq_i;
      sync2  <= sync1;
      sync3  <= sync2;
      inta_d <= inta_i;
    end
  end

  assign irq_rise = sync2 & ~sync3;

  // --------------------------------------------------------------------------
  // Priority resolution. x & -x isolates the lowest set bit, i.e. the highest
  // priority; comparing two one-hot words orders them by index.
  // --------------------------------------------------------------------------
  assign pend     = irr & ~imr;
  assign win_oh   = pend & (-pend);
  assign isr_oh   = isr & (-isr);
  assign eligible = (|win_oh) && ((isr == '0) || (win_oh < isr_oh));

  always_comb begin
    win_idx = 3'd0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend[i]) win_idx = 3'(i);
    end
  end

  // --------------------------------------------------------------------------
  // Bus decode. A new access starts only while ack is low, so a held strobe
  // cannot produce back-to-back acks.
  // --------------------------------------------------------------------------
  assign acc = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr  = acc & wb_we_i;
  assign eoi = wr & wb_adr_i & wb_sel_i[1];

  always_comb begin
    imr8 = '0;
    irr8 = '0;
    isr8 = '0;
    imr8[NIRQ-1:0] = imr;
    irr8[NIRQ-1:0] = irr;
    isr8[NIRQ-1:0] = isr;
    rd_data = wb_adr_i ? {isr8, base, 3'b000} : {irr8, imr8};
  end

  // --------------------------------------------------------------------------
  // IRR / ISR update. An edge arriving while the same bit is being taken by
  // the acknowledge re-sets it (set wins). EOI retires the highest-priority
  // in-service bit; with ISR empty isr_oh is zero so EOI does nothing.
  // --------------------------------------------------------------------------
  assign take      = (state == ACK) && eligible;
  assign take_mask = take ? win_oh : '0;
  assign eoi_mask  = eoi ? isr_oh : '0;
  assign irr_nx    = (irr & ~take_mask) | irq_rise;
  assign isr_nx    = (isr & ~eoi_mask) | take_mask;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irr <= '0;
      isr <= '0;
    end else begin
      irr <= irr_nx;
      isr <= isr_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Bus registers. Writes land on the edge that raises ack so the new value is
  // visible during the ack cycle; read data is registered alongside ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      imr      <= '1;
      base     <= VEC_RST[7:3];
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc && !wb_we_i) wb_dat_o <= rd_data;
      if (wr && !wb_adr_i && wb_sel_i[0]) imr <= wb_dat_i[NIRQ-1:0];
      if (wr && wb_adr_i && wb_sel_i[0]) base <= wb_dat_i[7:3];
    end
  end

  // Vector is recomputed in ACK so a request masked at the last moment
  // yields the spurious vector instead of a stale one.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vec_o <= 8'h00;
    end else if (state == ACK) begin
      vec_o <= eligible ? {base, win_idx} : {base, 3'b111};
    end
  end

  // --------------------------------------------------------------------------
  // Acknowledge FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (eligible) state_nx = REQ;
      // An acknowledge already under way takes precedence over a lost
      // eligibility; ACK then resolves it as spurious.
      REQ: begin
        if (inta_i && !inta_d) state_nx = ACK;
        else if (!eligible)    state_nx = IDLE;
      end
      ACK:  state_nx = HOLD;
      HOLD: if (!inta_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign intr_o = (state == REQ);

endmodule
`default_nettype wire

// File: tb/tb_wb_pic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_pic
//  Purpose  : Self-checking bench for wb_pic: a register-map vector table
//             followed by hand-written interrupt sequences. Expected values go
//             into a scoreboard queue when a read or acknowledge is launched
//             and are popped when the DUT answers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_pic;

  logic        clk;
  logic        rst_n;
  logic        adr;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic [1:0]  sel;
  logic        we, stb, cyc, ack;
  logic [7:0]  irq;
  logic        intr, inta;
  logic [7:0]  vec;

  wb_pic #(.NIRQ(8), .VEC_RST(8'h08)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .irq_i    (irq),
    .intr_o   (intr),
    .inta_i   (inta),
    .vec_o    (vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic        adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wdat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  task automatic bus(input logic a, input logic w, input logic [1:0] s,
                     input logic [15:0] d, output logic [15:0] rd, output bit ok);
    @(posedge clk); #1;
    adr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
    ok = 1'b0;
    rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) begin
        ok = 1'b1;
        rd = dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input string name, input logic a, input logic [1:0] s,
                           input logic [15:0] d);
    logic [15:0] rd;
    bit ok;
    bus(a, 1'b1, s, d, rd, ok);
    if (!ok) timeout_fail(name);
  endtask

  task automatic bus_read(input string name, input logic a, input logic [15:0] exp);
    logic [15:0] rd;
    bit ok;
    sb_t e;
    sbq.push_back('{name, exp});
    bus(a, 1'b0, 2'b11, 16'h0000, rd, ok);
    e = sbq.pop_front();
    if (!ok) timeout_fail(e.name);
    else     check(e.name, rd, e.exp);
  endtask

  task automatic eoi();
    bus_write("eoi", 1'b1, 2'b10, 16'h0000);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    @(posedge clk); #1;
    irq = m;
    repeat (3) @(posedge clk);
    #1;
    irq = 8'h00;
  endtask

  task automatic wait_intr(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (intr) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) check(name, {15'd0, intr}, 16'h0001);
    else      timeout_fail(name);
  endtask

  // Acknowledge cycle: intr_o must be low during ACK, vector valid in HOLD.
  task automatic do_inta(input string name, input logic [7:0] exp);
    sb_t e;
    sbq.push_back('{name, {8'h00, exp}});
    @(posedge clk); #1;
    inta = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_intr_drop"}, {15'd0, intr}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    check(e.name, {8'h00, vec}, e.exp);
    @(posedge clk); #1;
    inta = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; adr = 1'b0; dat_i = '0; sel = '0; we = 1'b0;
    stb = 1'b0; cyc = 1'b0; irq = '0; inta = 1'b0;

    tbl[0]  = '{"rst_word0",      1'b0, 1'b0, 2'b11, 16'h0000, 16'h00FF};
    tbl[1]  = '{"rst_word1",      1'b1, 1'b0, 2'b11, 16'h0000, 16'h0008};
    tbl[2]  = '{"wr_base27",      1'b1, 1'b1, 2'b01, 16'h0027, 16'h0000};
    tbl[3]  = '{"base_rd20",      1'b1, 1'b0, 2'b11, 16'h0000, 16'h0020};
    tbl[4]  = '{"wr_w0_both",     1'b0, 1'b1, 2'b11, 16'hAB5A, 16'h0000};
    tbl[5]  = '{"imr_5a_irr_ro",  1'b0, 1'b0, 2'b11, 16'h0000, 16'h005A};
    tbl[6]  = '{"wr_w0_hi_only",  1'b0, 1'b1, 2'b10, 16'h0033, 16'h0000};
    tbl[7]  = '{"imr_lane_held",  1'b0, 1'b0, 2'b11, 16'h0000, 16'h005A};
    tbl[8]  = '{"eoi_isr_empty",  1'b1, 1'b1, 2'b10, 16'hFFFF, 16'h0000};
    tbl[9]  = '{"eoi_noop_rd",    1'b1, 1'b0, 2'b11, 16'h0000, 16'h0020};
    tbl[10] = '{"restore_base",   1'b1, 1'b1, 2'b01, 16'h0008, 16'h0000};
    tbl[11] = '{"restore_imr",    1'b0, 1'b1, 2'b01, 16'h00FF, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_intr", {15'd0, intr}, 16'h0000);
    check("rst_vec",  {8'h00, vec},  16'h0000);
    check("rst_ack",  {15'd0, ack},  16'h0000);
    check("rst_dat",  dat_o,         16'h0000);
    rst_n = 1'b1;

    // Register map table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) bus_write(tbl[i].name, tbl[i].adr, tbl[i].sel, tbl[i].wdat);
      else           bus_read(tbl[i].name, tbl[i].adr, tbl[i].exp);
    end

    // Single request, latency from edge to intr_o
    bus_write("imr_fe", 1'b0, 2'b01, 16'h00FE);
    @(posedge clk); #1;
    irq = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    irq = 8'h00;
    @(negedge clk);
    check("t1_lat3_low", {15'd0, intr}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("t1_lat4_high", {15'd0, intr}, 16'h0001);
    do_inta("t1_vec", 8'h08);
    bus_read("t1_isr", 1'b1, 16'h0108);
    bus_read("t1_irr", 1'b0, 16'h00FE);
    eoi();
    bus_read("t1_isr_clr", 1'b1, 16'h0008);

    // Two simultaneous requests, lower waits for EOI
    bus_write("imr_00", 1'b0, 2'b01, 16'h0000);
    pulse_irq(8'h24);
    wait_intr("t2_intr");
    do_inta("t2_vec_a", 8'h0A);
    repeat (3) @(negedge clk);
    check("t2_blocked", {15'd0, intr}, 16'h0000);
    bus_read("t2_irr5", 1'b0, 16'h2000);
    bus_read("t2_isr2", 1'b1, 16'h0408);
    eoi();
    wait_intr("t2_after_eoi");
    do_inta("t2_vec_d", 8'h0D);
    eoi();

    // Nesting
    pulse_irq(8'h10);
    wait_intr("t3_intr4");
    do_inta("t3_vec_c", 8'h0C);
    pulse_irq(8'h02);
    wait_intr("t3_nest_intr");
    do_inta("t3_vec_9", 8'h09);
    bus_read("t3_isr12", 1'b1, 16'h1208);
    eoi();
    bus_read("t3_isr10", 1'b1, 16'h1008);
    eoi();
    bus_read("t3_isr0", 1'b1, 16'h0008);

    // Mask while requesting
    pulse_irq(8'h08);
    wait_intr("t4_intr");
    bus_write("imr_08", 1'b0, 2'b01, 16'h0008);
    @(negedge clk);
    check("t4_masked_drop", {15'd0, intr}, 16'h0000);
    bus_read("t4_irr_kept", 1'b0, 16'h0808);
    bus_write("imr_00b", 1'b0, 2'b01, 16'h0000);
    wait_intr("t4_unmask");
    do_inta("t4_vec_b", 8'h0B);
    eoi();

    // Spurious acknowledge: mask lands in the cycle inta rises
    pulse_irq(8'h40);
    wait_intr("t5_intr");
    @(posedge clk); #1;
    adr = 1'b0; we = 1'b1; sel = 2'b01; dat_i = 16'h0040; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    inta = 1'b1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    begin
      sb_t e;
      sbq.push_back('{"t5_spurious_vec", 16'h000F});
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      e = sbq.pop_front();
      check(e.name, {8'h00, vec}, e.exp);
    end
    @(posedge clk); #1;
    inta = 1'b0;
    repeat (2) @(posedge clk);
    bus_read("t5_isr_same", 1'b1, 16'h0008);
    bus_read("t5_irr_kept", 1'b0, 16'h4040);
    bus_write("imr_00c", 1'b0, 2'b01, 16'h0000);
    wait_intr("t5_reassert");
    do_inta("t5_vec_e", 8'h0E);
    eoi();

    // Ack is a single cycle even with strobe held
    @(posedge clk); #1;
    adr = 1'b1; we = 1'b0; sel = 2'b11; stb = 1'b1; cyc = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (ack) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout_fail("t6_ack");
      @(negedge clk);
      check("t6_ack_single", {15'd0, ack}, 16'h0000);
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of HOLD
    bus_write("base_30", 1'b1, 2'b01, 16'h0030);
    pulse_irq(8'h04);
    wait_intr("t7_intr");
    @(posedge clk); #1;
    inta = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t7_vec_pre", {8'h00, vec}, 16'h0032);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_intr", {15'd0, intr}, 16'h0000);
    check("t7_rst_vec",  {8'h00, vec},  16'h0000);
    check("t7_rst_dat",  dat_o,         16'h0000);
    inta = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read("t7_imr_ff", 1'b0, 16'h00FF);
    bus_read("t7_base_08", 1'b1, 16'h0008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
